// File: rtl/acc_cpu_core.sv
// ---------------------------------------------------------------------------
// acc_cpu_core
//   Parametrised accumulator CPU. It drives one shared address bus and one
//   shared data bus, and READ_write qualifies each bus cycle. Every access
//   waits for mem_ready, so any non-HALT state holds until memory completes
//   the access.
//
//   Instruction set (opcode = low 8 bits of the fetched word):
//     EA NOP, 18 CLC, 38 SEC, A9 LDA #imm, 69 ADC #imm,
//     8D STA abs, 4C JMP abs, 02 HLT. Any unlisted opcode executes as a NOP.
//
// Ports
//   clk_in      : system clock, rising edge
//   reset       : asynchronous, active-high reset
//   mem_ready   : 1 = memory completes the current access on this edge
//   data_in     : read data, sampled on a rising edge with mem_ready = 1
//   data_out    : write data (A during WRITE, 0 otherwise)
//   address_out : current bus address
//   READ_write  : 1 = read cycle, 0 = write cycle
//   sync        : high during the opcode fetch cycle
//   halted      : high in HALT
//   flags       : {N, V, Z, C}
// ---------------------------------------------------------------------------
module acc_cpu_core #(
  parameter int                  DATA_W   = 8,
  parameter logic [2*DATA_W-1:0] RESET_PC = {(2*DATA_W){1'b0}}
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic [2*DATA_W-1:0]   address_out,
  output logic                  READ_write,
  output logic                  sync,
  output logic                  halted,
  output logic [3:0]            flags
);

  localparam int ADDR_W = 2 * DATA_W;

  localparam logic [7:0] OP_NOP = 8'hEA;
  localparam logic [7:0] OP_CLC = 8'h18;
  localparam logic [7:0] OP_SEC = 8'h38;
  localparam logic [7:0] OP_LDA = 8'hA9;
  localparam logic [7:0] OP_ADC = 8'h69;
  localparam logic [7:0] OP_STA = 8'h8D;
  localparam logic [7:0] OP_JMP = 8'h4C;
  localparam logic [7:0] OP_HLT = 8'h02;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_OPERAND_HI = 3'd2,
    ST_WRITE      = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  // Signed overflow of a + b (+ carry): the operands share a sign and the
  // result sign differs from it.
  function automatic logic add_overflow(
    input logic a_msb,
    input logic b_msb,
    input logic r_msb
  );
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Architectural registers
  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [DATA_W-1:0]   acc_r;
  logic [7:0]          ir_r;
  logic [DATA_W-1:0]   lo_r;
  logic [DATA_W-1:0]   hi_r;
  logic                flag_n_r;
  logic                flag_v_r;
  logic                flag_z_r;
  logic                flag_c_r;

  // Next-state values
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   pc_nxt_s;
  logic [ADDR_W-1:0]   pc_inc_s;
  logic [DATA_W-1:0]   acc_nxt_s;
  logic [7:0]          ir_nxt_s;
  logic [DATA_W-1:0]   lo_nxt_s;
  logic [DATA_W-1:0]   hi_nxt_s;
  logic                flag_n_nxt_s;
  logic                flag_v_nxt_s;
  logic                flag_z_nxt_s;
  logic                flag_c_nxt_s;
  logic [DATA_W:0]     sum_s;

  // Next bus outputs, registered so the pins come straight from flops
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic                rw_nxt_s;
  logic [DATA_W-1:0]   dout_nxt_s;
  logic                sync_nxt_s;
  logic                halted_nxt_s;

  // PC increment (wraps at the ADDR_W modulus) and carry-aware adder
  always_comb begin
    pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    sum_s    = {1'b0, acc_r} + {1'b0, data_in} + {{DATA_W{1'b0}}, flag_c_r};
  end

  // Instruction sequencing and datapath next-state
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    acc_nxt_s    = acc_r;
    ir_nxt_s     = ir_r;
    lo_nxt_s     = lo_r;
    hi_nxt_s     = hi_r;
    flag_n_nxt_s = flag_n_r;
    flag_v_nxt_s = flag_v_r;
    flag_z_nxt_s = flag_z_r;
    flag_c_nxt_s = flag_c_r;

    if (state_r == ST_HALT) begin
      // HALT ignores mem_ready; only reset leaves it.
      state_nxt_s = ST_HALT;
    end else if (mem_ready) begin
      case (state_r)
        ST_FETCH: begin
          ir_nxt_s    = data_in[7:0];
          pc_nxt_s    = pc_inc_s;
          state_nxt_s = ST_DECODE;
        end

        ST_DECODE: begin
          case (ir_r)
            OP_CLC: begin
              flag_c_nxt_s = 1'b0;
              state_nxt_s  = ST_FETCH;
            end
            OP_SEC: begin
              flag_c_nxt_s = 1'b1;
              state_nxt_s  = ST_FETCH;
            end
            OP_LDA: begin
              acc_nxt_s    = data_in;
              flag_z_nxt_s = (data_in == {DATA_W{1'b0}});
              flag_n_nxt_s = data_in[DATA_W-1];
              pc_nxt_s     = pc_inc_s;
              state_nxt_s  = ST_FETCH;
            end
            OP_ADC: begin
              acc_nxt_s    = sum_s[DATA_W-1:0];
              flag_c_nxt_s = sum_s[DATA_W];
              flag_z_nxt_s = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
              flag_n_nxt_s = sum_s[DATA_W-1];
              flag_v_nxt_s = add_overflow(acc_r[DATA_W-1], data_in[DATA_W-1],
                                          sum_s[DATA_W-1]);
              pc_nxt_s     = pc_inc_s;
              state_nxt_s  = ST_FETCH;
            end
            OP_STA, OP_JMP: begin
              lo_nxt_s    = data_in;
              pc_nxt_s    = pc_inc_s;
              state_nxt_s = ST_OPERAND_HI;
            end
            OP_HLT: begin
              state_nxt_s = ST_HALT;
            end
            OP_NOP: begin
              state_nxt_s = ST_FETCH;
            end
            default: begin
              // Unlisted opcodes consume no operand and behave as NOP.
              state_nxt_s = ST_FETCH;
            end
          endcase
        end

        ST_OPERAND_HI: begin
          if (ir_r == OP_STA) begin
            hi_nxt_s    = data_in;
            pc_nxt_s    = pc_inc_s;
            state_nxt_s = ST_WRITE;
          end else if (ir_r == OP_JMP) begin
            pc_nxt_s    = {data_in, lo_r};
            state_nxt_s = ST_FETCH;
          end else begin
            // Only STA and JMP reach this state; anything else re-fetches.
            state_nxt_s = ST_FETCH;
          end
        end

        ST_WRITE: begin
          state_nxt_s = ST_FETCH;
        end

        default: begin
          // Unreachable encodings recover through a fresh fetch.
          state_nxt_s = ST_FETCH;
        end
      endcase
    end else begin
      // Wait state: every register keeps its value.
      state_nxt_s = state_r;
    end
  end

  // Bus outputs for the state being entered
  always_comb begin
    addr_nxt_s   = pc_nxt_s;
    rw_nxt_s     = 1'b1;
    dout_nxt_s   = {DATA_W{1'b0}};
    sync_nxt_s   = 1'b0;
    halted_nxt_s = 1'b0;

    case (state_nxt_s)
      ST_FETCH: begin
        sync_nxt_s = 1'b1;
      end
      ST_DECODE, ST_OPERAND_HI: begin
        addr_nxt_s = pc_nxt_s;
      end
      ST_WRITE: begin
        addr_nxt_s = {hi_nxt_s, lo_nxt_s};
        rw_nxt_s   = 1'b0;
        dout_nxt_s = acc_nxt_s;
      end
      ST_HALT: begin
        halted_nxt_s = 1'b1;
      end
      default: begin
        addr_nxt_s = pc_nxt_s;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      acc_r       <= {DATA_W{1'b0}};
      ir_r        <= 8'h00;
      lo_r        <= {DATA_W{1'b0}};
      hi_r        <= {DATA_W{1'b0}};
      flag_n_r    <= 1'b0;
      flag_v_r    <= 1'b0;
      flag_z_r    <= 1'b0;
      flag_c_r    <= 1'b0;
      address_out <= RESET_PC;
      READ_write  <= 1'b1;
      data_out    <= {DATA_W{1'b0}};
      sync        <= 1'b1;
      halted      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      acc_r       <= acc_nxt_s;
      ir_r        <= ir_nxt_s;
      lo_r        <= lo_nxt_s;
      hi_r        <= hi_nxt_s;
      flag_n_r    <= flag_n_nxt_s;
      flag_v_r    <= flag_v_nxt_s;
      flag_z_r    <= flag_z_nxt_s;
      flag_c_r    <= flag_c_nxt_s;
      address_out <= addr_nxt_s;
      READ_write  <= rw_nxt_s;
      data_out    <= dout_nxt_s;
      sync        <= sync_nxt_s;
      halted      <= halted_nxt_s;
    end
  end

  assign flags = {flag_n_r, flag_v_r, flag_z_r, flag_c_r};

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised successor to the 8-bit accumulator CPU. Generalised data width, configurable reset vector, memory wait-state handshake (`mem_ready`), carry-aware ADC, full N/Z/C/V flags, absolute-address store and jump, and a halt state.
- Sits between the memory/bus fabric and the system top level.
- Drives one shared address bus and one shared data bus, with `READ_write` qualifying each cycle.

Parameters:
- DATA_W, 8: data/accumulator width. Must be ≥ 8. Opcode = low 8 bits of the fetched word.
- RESET_PC, 16'h0000: PC value on reset. Width ADDR_W.
- ADDR_W, 2*DATA_W: localparam. Address = {hi operand, lo operand}.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  1 = memory completes the current access this cycle. 0 = stall.
- data_in  in  DATA_W  read data, sampled on the clk_in edge when mem_ready=1.
- data_out  out  DATA_W  write data. Equals A in WRITE state, 0 otherwise.
- address_out  out  ADDR_W  current bus address.
- READ_write  out  1  1 = read, 0 = write.
- sync  out  1  high during the FETCH state (opcode read).
- halted  out  1  high in HALT state.
- flags  out  4  {N,V,Z,C}.

Behaviour:
- Reset (async, immediate):
  - Registers: state=FETCH, PC=RESET_PC, A=0, IR=0, operand latch=0, flags=0.
  - Outputs during reset: address_out=RESET_PC, READ_write=1, sync=1, halted=0, data_out=0.
  - Reset in any state, including mid-WRITE, aborts the operation. No partial register update.
- States: FETCH, DECODE, OPERAND_HI, WRITE, HALT.
- Stall: in any non-HALT state with mem_ready=0, nothing changes (state, PC, A, IR, flags, latch) and all outputs hold. A state advances only on an edge with mem_ready=1.
- FETCH:
  - address=PC, read, sync=1.
  - IR <= data_in[7:0]; PC <= PC+1; next state DECODE.
- DECODE: address=PC, read. Action by IR:
  - EA NOP; also any unlisted opcode:
    - No operand consumed, PC unchanged.
    - Next state FETCH.
  - 18 CLC / 38 SEC:
    - C <= 0 / C <= 1.
    - No operand consumed; next state FETCH.
  - A9 LDA #imm:
    - A <= data_in; PC++.
    - Z <= (data_in==0); N <= data_in[MSB]; C and V unchanged.
    - Next state FETCH.
  - 69 ADC #imm:
    - sum[DATA_W:0] = A + data_in + C.
    - A <= sum[DATA_W-1:0]; C <= sum[DATA_W]; Z <= result==0; N <= result MSB.
    - V <= (A[MSB]==imm[MSB]) && (result[MSB]!=A[MSB]).
    - PC++; next state FETCH.
  - 8D STA abs / 4C JMP abs:
    - lo latch <= data_in; PC++.
    - Next state OPERAND_HI.
  - 02 HLT: next state HALT; PC unchanged.
- OPERAND_HI: address=PC, read.
  - STA: hi latch <= data_in; PC++; next state WRITE.
  - JMP: PC <= {data_in, lo}; next state FETCH.
- WRITE: address={hi,lo}, READ_write=0, data_out=A. On mem_ready=1, next state FETCH.
- HALT:
  - address=PC, read, halted=1.
  - mem_ready is ignored. Only reset exits.
- Cycle counts with no stalls:
  - NOP/CLC/SEC/LDA/ADC: 2.
  - JMP: 3.
  - STA: 4.
  - Each mem_ready=0 cycle adds 1.
- Wrap-around:
  - PC FFFF+1 -> 0000 at DATA_W=8; generally the ADDR_W modulus.
  - ADC result wraps mod 2^DATA_W, with carry out to C.
- Operand bytes read at PC are never decoded as opcodes.

Test Plan:
- Reset; memory {A9 05, 69 FB} at 0000 -> after 4 cycles A=00, C=1, Z=1, N=0, V=0.
- SEC then LDA #7F, ADC #00 -> A=80, N=1, V=1, C=0, Z=0.
- LDA #3C; STA $1234 -> a write cycle with address_out=1234, data_out=3C, READ_write=0, exactly 4 cycles after the STA opcode fetch begins.
- JMP $FFFF placed at RESET_PC; at FFFF: opcode EA; at 0000: opcode A9 11 -> after the NOP, PC wraps to 0000 and A=11.
- Hold mem_ready=0 for 3 cycles during the ADC operand read -> A, PC, flags and outputs all unchanged for those 3 cycles; update completes on the first cycle with mem_ready=1.
- HLT (02) -> halted=1 and stays high for 20 cycles with mem_ready toggling. Assert reset mid-WRITE of a later STA -> READ_write=1 and address_out=RESET_PC immediately, no memory write completed.
